// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// ----------------------------------------------------------------------------
// Write-back controller for a register file with one write port. It collects
// results from two producers, EXU and LSU. Completed results wait in an
// in-order FIFO of DEPTH entries. The FIFO head drives the register file write
// port. A bypass query lets the read side see values that are still pending.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   exu_valid/ready/rd/data     EXU result handshake (lower priority)
//   lsu_valid/ready/rd/data     LSU result handshake (higher priority)
//   wb_stall                    holds the write port; nothing drains while high
//   Rw, busW, RegWr             register file write port (from the FIFO head)
//   q_addr, q_hit, q_data       bypass query (youngest pending write wins)
//   count                       FIFO occupancy
//
// Ready, RegWr and the query outputs are combinational on purpose. The
// surrounding pipeline needs same-cycle handshakes and same-cycle stall
// response. Writes to x0 complete their handshake but are never enqueued.
// ----------------------------------------------------------------------------
module regfile_wb_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    exu_valid,
    output logic                    exu_ready,
    input  logic [ADDR_WIDTH-1:0]   exu_rd,
    input  logic [DATA_WIDTH-1:0]   exu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_rd,
    input  logic [DATA_WIDTH-1:0]   lsu_data,
    input  logic                    wb_stall,
    output logic [ADDR_WIDTH-1:0]   Rw,
    output logic [DATA_WIDTH-1:0]   busW,
    output logic                    RegWr,
    input  logic [ADDR_WIDTH-1:0]   q_addr,
    output logic                    q_hit,
    output logic [DATA_WIDTH-1:0]   q_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    // FIFO storage and control state
    logic [ADDR_WIDTH-1:0] rd_mem_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    logic                  full_s;
    logic                  empty_s;
    logic                  lsu_hs_s;
    logic                  exu_hs_s;
    logic                  enq_s;
    logic                  deq_s;
    logic [ADDR_WIDTH-1:0] enq_rd_s;
    logic [DATA_WIDTH-1:0] enq_data_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Ready depends only on occupancy and the LSU request. It does not depend
    // on rd or on a same-cycle drain, so a full FIFO refuses input even while
    // it writes back.
    assign lsu_ready = !full_s;
    assign exu_ready = !full_s && !lsu_valid;
    assign lsu_hs_s  = lsu_valid && lsu_ready;
    assign exu_hs_s  = exu_valid && exu_ready;

    // Write port driven straight from the FIFO head
    assign RegWr = !empty_s && !wb_stall;
    assign Rw    = empty_s ? ZERO_ADDR : rd_mem_q[rd_ptr_q];
    assign busW  = empty_s ? ZERO_DATA : data_mem_q[rd_ptr_q];
    assign deq_s = RegWr;
    assign count = count_q;

    // Select the granted source; an x0 destination completes without enqueueing
    always_comb begin
        enq_s      = 1'b0;
        enq_rd_s   = ZERO_ADDR;
        enq_data_s = ZERO_DATA;
        if (lsu_hs_s) begin
            enq_s      = (lsu_rd != ZERO_ADDR);
            enq_rd_s   = lsu_rd;
            enq_data_s = lsu_data;
        end else if (exu_hs_s) begin
            enq_s      = (exu_rd != ZERO_ADDR);
            enq_rd_s   = exu_rd;
            enq_data_s = exu_data;
        end else begin
            enq_s      = 1'b0;
        end
    end

    // Next-state pointers and occupancy
    always_comb begin
        rd_ptr_d = deq_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        wr_ptr_d = enq_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards every pending entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage. Contents are don't-care until covered by count, so there
    // is no reset.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            rd_mem_q[wr_ptr_q]   <= enq_rd_s;
            data_mem_q[wr_ptr_q] <= enq_data_s;
        end
    end

    // Bypass query. Scan from oldest to youngest so that a later match
    // overrides an earlier one. The head being written this cycle is still
    // counted as pending.
    always_comb begin
        q_hit  = 1'b0;
        q_data = ZERO_DATA;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && (q_addr != ZERO_ADDR) &&
                (rd_mem_q[rd_ptr_q + PTR_W'(k)] == q_addr)) begin
                q_hit  = 1'b1;
                q_data = data_mem_q[rd_ptr_q + PTR_W'(k)];
            end else begin
                q_hit  = q_hit;
                q_data = q_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          exu_valid = 1'b0;
    logic          exu_ready;
    logic [AW-1:0] exu_rd = 5'd0;
    logic [DW-1:0] exu_data = 32'd0;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd = 5'd0;
    logic [DW-1:0] lsu_data = 32'd0;
    logic          wb_stall = 1'b0;
    logic [AW-1:0] Rw;
    logic [DW-1:0] busW;
    logic          RegWr;
    logic [AW-1:0] q_addr = 5'd0;
    logic          q_hit;
    logic [DW-1:0] q_data;
    logic [2:0]    count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected write-back order: pushed when the bench sees an accepted
    // transfer, popped when the DUT drives the write port.
    wb_t exp_q[$];
    logic m_full, m_deq;
    wb_t  m_head;

    regfile_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_stall(wb_stall), .Rw(Rw), .busW(busW), .RegWr(RegWr),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .count(count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: checks every write-port cycle against the model queue
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            m_full = (exp_q.size() == DEPTH);
            m_deq  = (exp_q.size() != 0) && !wb_stall;
            tests_run++;
            if (RegWr !== m_deq) begin
                tests_failed++;
                $display("FAIL sb_regwr t=%0t got=%b exp=%b", $time, RegWr, m_deq);
            end
            tests_run++;
            if (count !== 3'(exp_q.size())) begin
                tests_failed++;
                $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, count, exp_q.size());
            end
            if (m_deq) begin
                m_head = exp_q.pop_front();
                tests_run++;
                if (Rw !== m_head.rd || busW !== m_head.data) begin
                    tests_failed++;
                    $display("FAIL sb_write t=%0t got=x%0d/%h exp=x%0d/%h",
                             $time, Rw, busW, m_head.rd, m_head.data);
                end
            end
            if (!m_full) begin
                if (lsu_valid) begin
                    if (lsu_rd != 5'd0) exp_q.push_back({lsu_rd, lsu_data});
                end else if (exu_valid) begin
                    if (exu_rd != 5'd0) exp_q.push_back({exu_rd, exu_data});
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((count !== 3'd0 || exp_q.size() != 0) && n < 20) begin
            next_cycle();
            n++;
        end
        tests_run++;
        if (n >= 20) begin
            tests_failed++;
            $display("FAIL %s_drain_timeout count=%0d exp=0", name, count);
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'd0 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_port got=%b/%0d/%h/%0d exp=0/0/0/0", RegWr, Rw, busW, count);
        end
        tests_run++;
        if (q_hit !== 1'b0 || q_data !== 32'd0 || lsu_ready !== 1'b1 || exu_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready got=%b/%h/%b/%b exp=0/0/1/1", q_hit, q_data, lsu_ready, exu_ready);
        end
        lsu_valid = 1'b1;
        #1;
        tests_run++;
        if (exu_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_exu_ready got=%b exp=0", exu_ready);
        end
        lsu_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_exu();
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF; q_addr = 5'd5;
        next_cycle();
        exu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (RegWr !== 1'b1 || Rw !== 5'd5 || busW !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", RegWr, Rw, busW);
        end
        tests_run++;
        if (q_hit !== 1'b1 || q_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL single_bypass got=%b/%h exp=1/deadbeef", q_hit, q_data);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (RegWr !== 1'b0 || count !== 3'd0 || q_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after got=%b/%0d/%b exp=0/0/0", RegWr, count, q_hit);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
        exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h22;
        @(negedge clk);
        tests_run++;
        if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL contention_ready got=%b/%b exp=1/0", lsu_ready, exu_ready);
        end
        next_cycle();
        lsu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (exu_ready !== 1'b1 || Rw !== 5'd3 || busW !== 32'h11) begin
            tests_failed++;
            $display("FAIL contention_second got=%b/x%0d/%h exp=1/x3/11", exu_ready, Rw, busW);
        end
        next_cycle();
        exu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (Rw !== 5'd4 || busW !== 32'h22) begin
            tests_failed++;
            $display("FAIL contention_order got=x%0d/%h exp=x4/22", Rw, busW);
        end
        wait_drain("contention");
    endtask

    task automatic test_x0_discard();
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h1234; q_addr = 5'd0;
        @(negedge clk);
        tests_run++;
        if (exu_ready !== 1'b1 || q_hit !== 1'b0 || q_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL x0_handshake got=%b/%b/%h exp=1/0/0", exu_ready, q_hit, q_data);
        end
        next_cycle();
        exu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (count !== 3'd0 || RegWr !== 1'b0 || q_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_discard got=%0d/%b/%b exp=0/0/0", count, RegWr, q_hit);
        end
        next_cycle();
    endtask

    task automatic test_stall_full();
        int n;
        wb_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = 32'h100 + 32'(i);
            @(negedge clk);
            tests_run++;
            if (lsu_ready !== (i <= 4) || count !== 3'(i - 1)) begin
                tests_failed++;
                $display("FAIL stall_fill_%0d got=%b/%0d exp=%b/%0d", i, lsu_ready, count, (i <= 4), i - 1);
            end
            if (i < 5) next_cycle();
        end
        next_cycle();
        wb_stall = 1'b0;
        n = 0;
        @(negedge clk);
        while (lsu_ready !== 1'b1 && n < 10) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != 1) begin
            tests_failed++;
            $display("FAIL stall_release got=%0d waits exp=1", n);
        end
        next_cycle();
        lsu_valid = 1'b0;
        wait_drain("stall");
    endtask

    task automatic test_bypass_youngest();
        wb_stall = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA;
        next_cycle();
        lsu_data = 32'hB;
        next_cycle();
        lsu_rd = 5'd9; lsu_data = 32'hC;
        q_addr = 5'd7;
        #1;
        tests_run++;
        if (q_hit !== 1'b1 || q_data !== 32'hB) begin
            tests_failed++;
            $display("FAIL bypass_youngest got=%b/%h exp=1/b", q_hit, q_data);
        end
        q_addr = 5'd9;
        #1;
        tests_run++;
        if (q_hit !== 1'b0 || q_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle got=%b/%h exp=0/0", q_hit, q_data);
        end
        next_cycle();
        lsu_valid = 1'b0;
        q_addr = 5'd8;
        #1;
        tests_run++;
        if (q_hit !== 1'b0 || q_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL bypass_miss got=%b/%h exp=0/0", q_hit, q_data);
        end
        q_addr = 5'd9;
        #1;
        tests_run++;
        if (q_hit !== 1'b1 || q_data !== 32'hC) begin
            tests_failed++;
            $display("FAIL bypass_x9 got=%b/%h exp=1/c", q_hit, q_data);
        end
        next_cycle();
        wb_stall = 1'b0;
        wait_drain("bypass");
    endtask

    task automatic test_reset_mid();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(20 + i); lsu_data = 32'hF00 + 32'(i);
            next_cycle();
        end
        lsu_valid = 1'b0;
        wb_stall = 1'b0;
        q_addr = 5'd21;
        #1;
        tests_run++;
        if (count !== 3'd3 || q_hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_pending got=%0d/%b exp=3/1", count, q_hit);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (count !== 3'd0 || RegWr !== 1'b0 || q_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_async got=%0d/%b/%b exp=0/0/0", count, RegWr, q_hit);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (RegWr !== 1'b0) begin
                tests_failed++;
                $display("FAIL rstmid_quiet_%0d got=%b exp=0", i, RegWr);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 32'hB2B0 + 32'(i);
            if (i > 0) begin
                @(negedge clk);
                tests_run++;
                if (RegWr !== 1'b1 || count !== 3'd1) begin
                    tests_failed++;
                    $display("FAIL b2b_rate_%0d got=%b/%0d exp=1/1", i, RegWr, count);
                end
            end
            next_cycle();
        end
        lsu_valid = 1'b0;
        wait_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_single_exu();
        test_contention();
        test_x0_discard();
        test_stall_full();
        test_bypass_youngest();
        test_reset_mid();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL final_queue got=%0d pending exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
